// File: rtl/regfile_sequencer.sv
// Command sequencer in front of the 8 x 16 register file: turns one-shot LDI/MOV/SWAP/CLR
// requests into registered REG_WE/select/data sequences over a Start/Busy/Done handshake.
module regfile_sequencer #(
    parameter int unsigned DataWidth  = 16,
    parameter int unsigned SelectSize = 3
) (
    input  logic                  Clk,
    input  logic                  Reset_N,
    input  logic                  Start,
    input  logic [1:0]            Cmd,
    input  logic [SelectSize-1:0] RegA,
    input  logic [SelectSize-1:0] RegB,
    input  logic [DataWidth-1:0]  Imm,
    output logic                  Busy,
    output logic                  Done,
    output logic [DataWidth-1:0]  Result,
    output logic                  REG_WE,
    output logic [SelectSize-1:0] REG_Dst,
    output logic [SelectSize-1:0] REG_Src1,
    output logic [SelectSize-1:0] REG_Src2,
    output logic [DataWidth-1:0]  DIn,
    input  logic [DataWidth-1:0]  SRC1,
    input  logic [DataWidth-1:0]  SRC2
);

    typedef enum logic [1:0] {
        CMD_LDI  = 2'b00,
        CMD_MOV  = 2'b01,
        CMD_SWAP = 2'b10,
        CMD_CLR  = 2'b11
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE1,
        S_WRITE2,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    cmd_t                  cmd_q;
    logic [SelectSize-1:0] rega_q, regb_q;
    logic [DataWidth-1:0]  imm_q, vala_q, valb_q;
    logic [SelectSize-1:0] cnt_q, cnt_d;

    logic                  we_d, busy_d, done_d;
    logic [SelectSize-1:0] dst_d, src1_d, src2_d;
    logic [DataWidth-1:0]  din_d, result_d;

    // Outputs are computed for the state being entered and registered, so they line up with state_q.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = 1'b1;
        dst_d    = REG_Dst;
        src1_d   = REG_Src1;
        src2_d   = REG_Src2;
        din_d    = DIn;
        done_d   = 1'b0;
        result_d = Result;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    case (cmd_t'(Cmd))
                        CMD_LDI:  state_d = S_WRITE1;
                        CMD_MOV,
                        CMD_SWAP: state_d = S_READ;
                        CMD_CLR:  state_d = S_CLEAR;
                        default:  state_d = S_IDLE;
                    endcase
                end
            end
            S_READ:   state_d = S_WRITE1;
            S_WRITE1: state_d = (cmd_q == CMD_SWAP) ? S_WRITE2 : S_DONE;
            S_WRITE2: state_d = S_DONE;
            S_CLEAR: begin
                if (cnt_q == '1) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        case (state_d)
            S_READ: begin
                src1_d = RegA;
                src2_d = RegB;
            end
            // WRITE1 is entered from IDLE (LDI, fields not yet latched) or from READ (data still on SRC2).
            S_WRITE1: begin
                we_d  = 1'b0;
                dst_d = (state_q == S_IDLE) ? RegA : rega_q;
                din_d = (state_q == S_IDLE) ? Imm  : SRC2;
            end
            S_WRITE2: begin
                we_d  = 1'b0;
                dst_d = regb_q;
                din_d = vala_q;
            end
            S_CLEAR: begin
                we_d  = 1'b0;
                dst_d = cnt_d;
                din_d = '0;
            end
            S_DONE: begin
                done_d = 1'b1;
                case (cmd_q)
                    CMD_LDI:  result_d = imm_q;
                    CMD_MOV,
                    CMD_SWAP: result_d = valb_q;
                    default:  result_d = '0;
                endcase
            end
            default: ;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            cmd_q    <= CMD_LDI;
            rega_q   <= '0;
            regb_q   <= '0;
            imm_q    <= '0;
            vala_q   <= '0;
            valb_q   <= '0;
            REG_WE   <= 1'b1;
            REG_Dst  <= '0;
            REG_Src1 <= '0;
            REG_Src2 <= '0;
            DIn      <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Result   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            REG_WE   <= we_d;
            REG_Dst  <= dst_d;
            REG_Src1 <= src1_d;
            REG_Src2 <= src2_d;
            DIn      <= din_d;
            Busy     <= busy_d;
            Done     <= done_d;
            Result   <= result_d;
            if (state_q == S_IDLE && Start) begin
                cmd_q  <= cmd_t'(Cmd);
                rega_q <= RegA;
                regb_q <= RegB;
                imm_q  <= Imm;
            end
            if (state_q == S_READ) begin
                vala_q <= SRC1;
                valb_q <= SRC2;
            end
        end
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: a behavioural register file on its write/read ports and a
// command-level model of the expected writes, latency, Result and final register contents.
module tb_regfile_sequencer;

    localparam int DW = 16;
    localparam int SW = 3;
    localparam int NR = 8;

    logic          Clock_TB = 1'b0;
    logic          Reset_N;
    logic          Start;
    logic [1:0]    Cmd;
    logic [SW-1:0] RegA, RegB;
    logic [DW-1:0] Imm;
    logic          Busy, Done, REG_WE;
    logic [DW-1:0] Result, DIn, SRC1, SRC2;
    logic [SW-1:0] REG_Dst, REG_Src1, REG_Src2;

    logic [DW-1:0] rf    [NR];
    logic [DW-1:0] model [NR];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 Clock_TB = ~Clock_TB;

    regfile_sequencer #(.DataWidth(DW), .SelectSize(SW)) dut (
        .Clk      (Clock_TB),
        .Reset_N  (Reset_N),
        .Start    (Start),
        .Cmd      (Cmd),
        .RegA     (RegA),
        .RegB     (RegB),
        .Imm      (Imm),
        .Busy     (Busy),
        .Done     (Done),
        .Result   (Result),
        .REG_WE   (REG_WE),
        .REG_Dst  (REG_Dst),
        .REG_Src1 (REG_Src1),
        .REG_Src2 (REG_Src2),
        .DIn      (DIn),
        .SRC1     (SRC1),
        .SRC2     (SRC2)
    );

    // Register file: active-low write on posedge, combinational reads.
    always @(posedge Clock_TB) if (!REG_WE) rf[REG_Dst] <= DIn;
    assign SRC1 = rf[REG_Src1];
    assign SRC2 = rf[REG_Src2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int r = 0; r < NR; r++)
            check($sformatf("%s_r%0d", tag, r), 32'(rf[r]), 32'(model[r]));
    endtask

    // Issue one command with Start high in cycle 0 and watch cycles 1..Done+1.
    // pulse_cyc > 0 re-asserts Start (as an LDI of 5555) during that cycle.
    task automatic run_cmd(input string tag, input logic [1:0] c, input int a, input int b,
                           input logic [DW-1:0] im, input int pulse_cyc);
        int            exp_lat;
        logic [DW-1:0] exp_res;
        int            wdst[$];
        logic [DW-1:0] wdat[$];
        int            odst[$];
        logic [DW-1:0] odat[$];
        int            done_cyc = -1;
        int            done_cnt = 0;
        int            busy_bad = 0;
        logic          busy_after = 1'b1;
        logic [DW-1:0] res_seen = '0;

        case (c)
            2'd0: begin wdst.push_back(a); wdat.push_back(im); exp_lat = 2; exp_res = im; end
            2'd1: begin wdst.push_back(a); wdat.push_back(model[b]); exp_lat = 3; exp_res = model[b]; end
            2'd2: begin
                wdst.push_back(a); wdat.push_back(model[b]);
                wdst.push_back(b); wdat.push_back(model[a]);
                exp_lat = 4; exp_res = model[b];
            end
            default: begin
                for (int r = 0; r < NR; r++) begin wdst.push_back(r); wdat.push_back('0); end
                exp_lat = NR + 1; exp_res = '0;
            end
        endcase

        @(negedge Clock_TB);
        Start = 1'b1; Cmd = c; RegA = SW'(a); RegB = SW'(b); Imm = im;
        for (int k = 1; k <= 20; k++) begin
            @(negedge Clock_TB);
            if (!REG_WE) begin odst.push_back(int'(REG_Dst)); odat.push_back(DIn); end
            if (Done) begin
                done_cnt++;
                if (done_cyc < 0) begin done_cyc = k; res_seen = Result; end
            end
            if (done_cyc < 0 || k <= done_cyc) begin
                if (!Busy) busy_bad++;
            end else begin
                busy_after = Busy;
            end
            if (k == 1) Start = 1'b0;
            if (k == pulse_cyc) begin Start = 1'b1; Cmd = 2'b00; Imm = 16'h5555; end
            else if (k == pulse_cyc + 1) Start = 1'b0;
            if (done_cyc >= 0 && k == done_cyc + 1) break;
        end
        Start = 1'b0;

        check({tag, "_latency"}, 32'(done_cyc), 32'(exp_lat));
        check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        check({tag, "_busy_during"}, 32'(busy_bad), 32'd0);
        check({tag, "_busy_after"}, 32'(busy_after), 32'd0);
        check({tag, "_result"}, 32'(res_seen), 32'(exp_res));
        check({tag, "_n_writes"}, 32'(odst.size()), 32'(wdst.size()));
        for (int i = 0; i < wdst.size() && i < odst.size(); i++) begin
            check($sformatf("%s_wdst%0d", tag, i), 32'(odst[i]), 32'(wdst[i]));
            check($sformatf("%s_wdat%0d", tag, i), 32'(odat[i]), 32'(wdat[i]));
        end
        for (int i = 0; i < wdst.size(); i++) model[wdst[i]] = wdat[i];
        check_regs(tag);
    endtask

    initial begin
        Reset_N = 1'b0; Start = 1'b0; Cmd = '0; RegA = '0; RegB = '0; Imm = '0;
        for (int r = 0; r < NR; r++) model[r] = '0;
        repeat (2) @(negedge Clock_TB);
        check("rst_we", 32'(REG_WE), 32'd1);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_result", 32'(Result), 32'd0);
        check("rst_dst", 32'(REG_Dst), 32'd0);
        check("rst_din", 32'(DIn), 32'd0);
        Reset_N = 1'b1;

        run_cmd("clr_init", 2'd3, 0, 0, '0, 0);
        run_cmd("ldi", 2'd0, 3, 0, 16'h00A0, 0);
        run_cmd("ldi_r1", 2'd0, 1, 0, 16'h000A, 0);
        run_cmd("mov", 2'd1, 5, 1, '0, 0);
        run_cmd("ldi_r2", 2'd0, 2, 0, 16'h1234, 0);
        run_cmd("ldi_r6", 2'd0, 6, 0, 16'hBEEF, 0);
        run_cmd("swap", 2'd2, 2, 6, '0, 0);
        run_cmd("swap_same", 2'd2, 2, 2, '0, 0);
        for (int r = 0; r < NR; r++) run_cmd("pre_ff", 2'd0, r, 0, 16'hFFFF, 0);
        run_cmd("clr", 2'd3, 0, 0, '0, 0);
        run_cmd("ldi_r2b", 2'd0, 2, 0, 16'h1234, 0);
        run_cmd("ldi_r6b", 2'd0, 6, 0, 16'hBEEF, 0);
        run_cmd("swap_pulse", 2'd2, 2, 6, '0, 1);

        // Reset during SWAP WRITE1: first write lands, second never happens.
        run_cmd("ldi_r2c", 2'd0, 2, 0, 16'h1234, 0);
        run_cmd("ldi_r6c", 2'd0, 6, 0, 16'hBEEF, 0);
        @(negedge Clock_TB);
        Start = 1'b1; Cmd = 2'd2; RegA = 3'd2; RegB = 3'd6;
        @(negedge Clock_TB);
        Start = 1'b0;
        @(negedge Clock_TB);
        check("abort_w1_we", 32'(REG_WE), 32'd0);
        check("abort_w1_dst", 32'(REG_Dst), 32'd2);
        Reset_N = 1'b0;
        @(negedge Clock_TB);
        check("abort_we", 32'(REG_WE), 32'd1);
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_done", 32'(Done), 32'd0);
        check("abort_result", 32'(Result), 32'd0);
        Reset_N = 1'b1;
        model[2] = 16'hBEEF;
        check_regs("abort");
        run_cmd("ldi_after", 2'd0, 4, 0, 16'h0C0C, 0);

        for (int n = 0; n < 24; n++) begin
            logic [1:0] c;
            c = 2'($urandom_range(0, 3));
            if (c == 2'd3 && $urandom_range(0, 3) != 0) c = 2'd0;
            run_cmd($sformatf("rnd%0d", n), c, int'($urandom_range(0, NR - 1)),
                    int'($urandom_range(0, NR - 1)), DW'($urandom), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
